// File: rtl/minesweeper_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | minesweeper_pkg: constants, placer state encoding and tile geometry      |
// | helpers shared by the board generator and the neighbour counter.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package minesweeper_pkg;

  localparam int          DEFAULT_NUM_SQUARES = 5;
  localparam logic [15:0] LFSR_MASK           = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED   = 16'hACE1;

  typedef enum logic [1:0] {
    PLACER_IDLE  = 2'd0,
    PLACER_PLACE = 2'd1,
    PLACER_DONE  = 2'd2
  } placer_state_e;

  typedef struct packed {
    logic [31:0] row;
    logic [31:0] col;
  } tile_pos_t;

  // Flat index is row*side + col; side is always an elaboration-time constant.
  function automatic tile_pos_t index_to_pos(input logic [31:0] index,
                                             input logic [31:0] side);
    tile_pos_t pos;
    pos.row = index / side;
    pos.col = index % side;
    return pos;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lfsr16: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with seed load.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lfsr16
  import minesweeper_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        en,
  output logic [15:0] state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      // The all-zero state is a lock-up state for this LFSR.
      state_d = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
    end else if (en) begin
      state_d = state_q[0] ? ((state_q >> 1) ^ LFSR_MASK) : (state_q >> 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LFSR_DEFAULT_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/mine_placer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mine_placer: places NUM_MINES mines on the board map using an LFSR,      |
// | never on the first-clicked tile. Option: MINE_PLACER_SAFE_ZONE_EN keeps  |
// | the whole 3x3 neighbourhood of the first click clear.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mine_placer
  import minesweeper_pkg::*;
#(
  parameter int NUM_SQUARES  = DEFAULT_NUM_SQUARES,
  parameter int NUM_MINES    = 5,
  parameter int INDEX_LENGTH = $clog2(NUM_SQUARES * NUM_SQUARES)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [15:0]                          seed,
  input  logic [INDEX_LENGTH-1:0]              safe_index,
  output logic                                 busy,
  output logic                                 done,
  output logic [NUM_SQUARES*NUM_SQUARES-1:0]   mine_map
);

  localparam int                 NUM_TILES  = NUM_SQUARES * NUM_SQUARES;
  localparam int                 COUNT_W    = $clog2(NUM_MINES + 1);
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(NUM_MINES - 1);

  placer_state_e          state_q, state_d;
  logic [NUM_TILES-1:0]   mine_map_q, mine_map_d;
  logic [COUNT_W-1:0]     count_q, count_d;
  logic [INDEX_LENGTH-1:0] safe_q, safe_d;

  logic [15:0]            lfsr_state;
  logic                   lfsr_load;
  logic                   lfsr_en;
  logic [INDEX_LENGTH-1:0] candidate;
  logic [NUM_TILES-1:0]   cand_onehot;
  logic                   in_range;
  logic                   occupied;
  logic                   safe_valid;
  logic                   excluded;
  logic                   accept;
  logic                   unused_lfsr_bits;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .seed  (seed),
    .en    (lfsr_en),
    .state (lfsr_state)
  );

  assign candidate        = lfsr_state[INDEX_LENGTH-1:0];
  assign unused_lfsr_bits = ^lfsr_state[15:INDEX_LENGTH];

  // Out-of-range candidates shift the one-hot off the top and leave it zero.
  assign cand_onehot = NUM_TILES'(1) << candidate;
  assign in_range    = 32'(candidate) < 32'(NUM_TILES);
  assign occupied    = |(mine_map_q & cand_onehot);
  assign safe_valid  = 32'(safe_q) < 32'(NUM_TILES);

`ifdef MINE_PLACER_SAFE_ZONE_EN
  tile_pos_t cand_pos;
  tile_pos_t safe_pos;

  always_comb begin
    cand_pos = index_to_pos(32'(candidate), 32'(NUM_SQUARES));
    safe_pos = index_to_pos(32'(safe_q), 32'(NUM_SQUARES));
    // Row and column distance of at most one; unsigned form avoids wrap at edges.
    excluded = safe_valid
            && (cand_pos.row + 32'd1 >= safe_pos.row)
            && (safe_pos.row + 32'd1 >= cand_pos.row)
            && (cand_pos.col + 32'd1 >= safe_pos.col)
            && (safe_pos.col + 32'd1 >= cand_pos.col);
  end
`else
  always_comb begin
    excluded = safe_valid && (candidate == safe_q);
  end
`endif

  assign accept = in_range && !occupied && !excluded;

  always_comb begin
    state_d    = state_q;
    mine_map_d = mine_map_q;
    count_d    = count_q;
    safe_d     = safe_q;
    lfsr_load  = 1'b0;
    lfsr_en    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      PLACER_IDLE: begin
        if (start) begin
          state_d    = PLACER_PLACE;
          mine_map_d = '0;
          count_d    = '0;
          safe_d     = safe_index;
          lfsr_load  = 1'b1;
        end
      end
      PLACER_PLACE: begin
        busy    = 1'b1;
        lfsr_en = 1'b1;
        if (accept) begin
          mine_map_d = mine_map_q | cand_onehot;
          count_d    = count_q + 1'b1;
          if (count_q == LAST_COUNT) begin
            state_d = PLACER_DONE;
          end
        end
      end
      PLACER_DONE: begin
        done    = 1'b1;
        state_d = PLACER_IDLE;
      end
      default: begin
        state_d = PLACER_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PLACER_IDLE;
      mine_map_q <= '0;
      count_q    <= '0;
      safe_q     <= '0;
    end else begin
      state_q    <= state_d;
      mine_map_q <= mine_map_d;
      count_q    <= count_d;
      safe_q     <= safe_d;
    end
  end

  assign mine_map = mine_map_q;

endmodule
`default_nettype wire

// File: tb/tb_mine_placer.sv
`default_nettype none
// Scoreboard bench for mine_placer: hand-derived boards are queued at start,
// a monitor pops and compares each one when done pulses.
module tb_mine_placer;

`ifdef MINE_PLACER_SAFE_ZONE_EN
  localparam int          M_FULL    = 16;
  localparam logic [24:0] SEED1_MAP = 25'h0500023;
  localparam int          SEED1_LAT = 16;
  localparam logic [24:0] ACE1_MAP  = 25'h1084202;
  localparam int          ACE1_LAT  = 9;
  localparam logic [24:0] FULL_MAP  = 25'h1F8C63F;
`else
  localparam int          M_FULL    = 24;
  localparam logic [24:0] SEED1_MAP = 25'h0110103;
  localparam int          SEED1_LAT = 11;
  localparam logic [24:0] ACE1_MAP  = 25'h1014082;
  localparam int          ACE1_LAT  = 7;
  localparam logic [24:0] FULL_MAP  = 25'h1FFEFFF;
`endif

  typedef struct {
    string       name;
    logic [24:0] exp_map;
    logic        exact;
    logic [24:0] zero_mask;
    int          lat;
    int          start_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start_f;
  logic [15:0] seed, seed_f;
  logic [4:0]  safe_index, safe_f;
  logic        busy, done, busy_f, done_f;
  logic [24:0] mine_map, map_f;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   wait_n;
  int   lat_meas;
  exp_t sb[$];
  exp_t mon_e;
  exp_t stim_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mine_placer #(.NUM_SQUARES(5), .NUM_MINES(5)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .safe_index(safe_index),
    .busy(busy), .done(done), .mine_map(mine_map)
  );

  mine_placer #(.NUM_SQUARES(5), .NUM_MINES(M_FULL)) dut_f (
    .clk(clk), .rst(rst), .start(start_f), .seed(seed_f), .safe_index(safe_f),
    .busy(busy_f), .done(done_f), .mine_map(map_f)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string nm, input logic [24:0] m, input logic ex,
                              input logic [24:0] z, input int lat);
    exp_t e;
    e.name = nm; e.exp_map = m; e.exact = ex; e.zero_mask = z; e.lat = lat; e.start_cyc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending board");
      end else begin
        mon_e    = sb.pop_front();
        lat_meas = cyc - mon_e.start_cyc + 1;
        check({mon_e.name, "_busy"}, 32'(busy), 32'd0);
        check({mon_e.name, "_popcount"}, 32'($countones(mine_map)), 32'd5);
        if (mon_e.exact) begin
          check({mon_e.name, "_map"}, 32'(mine_map), 32'(mon_e.exp_map));
          check({mon_e.name, "_latency"}, 32'(lat_meas), 32'(mon_e.lat));
        end else begin
          check({mon_e.name, "_excluded"}, 32'(mine_map & mon_e.zero_mask), 32'd0);
          check({mon_e.name, "_min_latency"}, 32'(lat_meas >= 6), 32'd1);
        end
      end
    end
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 2000 cycles", name);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_board(input logic [15:0] s, input logic [4:0] si, input exp_t e);
    exp_t q;
    @(negedge clk);
    seed = s; safe_index = si; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    q = e;
    q.start_cyc = cyc;
    sb.push_back(q);
    wait_drain(e.name);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_f = 1'b0;
    seed = '0; seed_f = '0; safe_index = '0; safe_f = 5'd12;
    repeat (2) @(negedge clk);
    check("reset_map", 32'(mine_map), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_map_full", 32'(map_f), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    run_board(16'h0001, 5'd12, mk("seed0001", SEED1_MAP, 1'b1, '0, SEED1_LAT));
    run_board(16'h0000, 5'd12, mk("seed0000", ACE1_MAP, 1'b1, '0, ACE1_LAT));
    run_board(16'hACE1, 5'd12, mk("seedACE1", ACE1_MAP, 1'b1, '0, ACE1_LAT));
`ifdef MINE_PLACER_SAFE_ZONE_EN
    run_board(16'h1234, 5'd12, mk("seed1234_a", '0, 1'b0, 25'h00739C0, 0));
    run_board(16'h1234, 5'd12, mk("seed1234_b", '0, 1'b0, 25'h00739C0, 0));
    run_board(16'h0001, 5'd0,  mk("corner0",    '0, 1'b0, 25'h0000063, 0));
    run_board(16'h1234, 5'd24, mk("corner24",   '0, 1'b0, 25'h18C0000, 0));
`else
    run_board(16'h1234, 5'd12, mk("seed1234_a", 25'h0122048, 1'b1, '0, 7));
    run_board(16'h1234, 5'd12, mk("seed1234_b", 25'h0122048, 1'b1, '0, 7));
    run_board(16'h0001, 5'd0,  mk("corner0",    25'h0112102, 1'b1, '0, 13));
    run_board(16'h1234, 5'd24, mk("corner24",   25'h0122048, 1'b1, '0, 7));
`endif

    // A start pulse mid-placement must neither alter nor queue a board.
    @(negedge clk);
    seed = 16'h0001; safe_index = 5'd12; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    stim_e = mk("ignored_start", SEED1_MAP, 1'b1, '0, SEED1_LAT);
    stim_e.start_cyc = cyc;
    sb.push_back(stim_e);
    repeat (3) @(negedge clk);
    seed = 16'hACE1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("ignored_start");
    repeat (4) @(negedge clk);
    check("ignored_start_idle", 32'(busy), 32'd0);

    // Asynchronous reset three cycles into placement.
    @(negedge clk);
    seed = 16'h0001; safe_index = 5'd12; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midplace_rst_map", 32'(mine_map), 32'd0);
    check("midplace_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Densest legal board on the second instance.
    @(negedge clk);
    seed_f = 16'h0001; safe_f = 5'd12; start_f = 1'b1;
    @(posedge clk);
    #1 start_f = 1'b0;
    wait_n = 0;
    while (done_f !== 1'b1 && wait_n < 5000) begin
      @(negedge clk);
      wait_n++;
    end
    check("full_done", 32'(done_f), 32'd1);
    if (done_f === 1'b1) begin
      check("full_map", 32'(map_f), 32'(FULL_MAP));
      check("full_busy", 32'(busy_f), 32'd0);
    end
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mine_placer.md
# mine_placer

Sequential generator for the board's `mine_map` vector, the single writer of the map that the combinational neighbour counter and reveal logic read. On a `start` request it clears the map and places exactly `NUM_MINES` mines at pseudo-random tiles using a 16-bit LFSR. It never places a mine on the first-clicked tile, so the opening click is always safe. Placement is deterministic for a given seed, so the bench can reproduce any board.

## Interface
- `NUM_SQUARES`, default 5: board side length; the board has NUM_SQUARES*NUM_SQUARES tiles.
- `NUM_MINES`, default 5: mines to place. Legal range is 1..N*N-1, or 1..N*N-9 with the safe zone enabled.
- `INDEX_LENGTH`, default $clog2(NUM_SQUARES*NUM_SQUARES): width of a flat tile index.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a new board; sampled only in IDLE.
- `seed`  in  16  LFSR seed, captured on an accepted `start`.
- `safe_index`  in  INDEX_LENGTH  flat index of the first click, captured on an accepted `start`.
- `busy`  out  1  high while placement is in progress.
- `done`  out  1  one-cycle pulse when the map is complete.
- `mine_map`  out  N*N  registered map; bit i is tile i, index = row*NUM_SQUARES + col.

## Operation
- States:
  - IDLE: `busy`=0.
  - PLACE: `busy`=1.
  - DONE: `busy`=0, `done`=1 for exactly one cycle, then IDLE.
- IDLE with `start`=1 → PLACE. On that edge:
  - `mine_map` clears to 0.
  - The placed counter clears to 0.
  - `safe_index` is latched.
  - The LFSR loads `seed`; a seed of 0x0000 is replaced by 0xACE1.
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 0xB400). It advances exactly once per PLACE cycle, whether the candidate is accepted or rejected.
- Candidate = low INDEX_LENGTH bits of the current LFSR state. The candidate is rejected if any of these hold:
  - candidate ≥ N*N;
  - `mine_map[candidate]` is already 1;
  - candidate lies in the excluded region (see Configuration).
- On acceptance, `mine_map[candidate]` is set and the counter increments. When the counter reaches NUM_MINES on an accepted placement → DONE.
- `start` is ignored in PLACE and DONE. It is not queued.
- `safe_index` ≥ N*N excludes nothing.
- Progress is guaranteed: the LFSR is maximal-length, so every INDEX_LENGTH-bit value recurs within 65535 steps.
- `mine_map` holds its value from DONE until the next accepted `start`.

## Timing
- Reset values:
  - state IDLE;
  - `busy`=0, `done`=0;
  - `mine_map`=0;
  - LFSR=0xACE1;
  - counter=0.
- Start timing: `start` is sampled at edge 0. `busy` rises after edge 0, and the first candidate is evaluated in the cycle after edge 0.
- Minimum latency, `start` edge to `done` high: NUM_MINES+1 cycles, reached when there are no rejections. Each rejection adds one cycle.
- The final mine bit and the `done` pulse become visible in the same cycle. Readers may sample `mine_map` from `done` onward.
- Reset asserted mid-placement: all reset values are restored immediately (asynchronous). No partial map survives.
- `start` held high continuously: a new placement begins in the cycle after DONE, so each board completes.

## Configuration
- `MINE_PLACER_SAFE_ZONE_EN` defined: the excluded region is the 3x3 block centred on `safe_index`, clipped at board edges.
  - Clipping uses the same row/column edge rules as the neighbour counter.
  - The first click is therefore guaranteed to have a count of 0.
- Undefined: only `safe_index` itself is excluded.

## Structure
- Shared package `minesweeper_pkg` holds:
  - default NUM_SQUARES;
  - LFSR mask 0xB400 and default seed 0xACE1;
  - the placer state enum;
  - a flat-index → row/col conversion function, shared with the neighbour counter.
- One sub-module: `lfsr16` (load, enable, 16-bit state output).
- Candidate qualification and the FSM stay in `mine_placer`.

## Test plan
- Reset, then N=5, M=5, seed 0x0001, safe 12, macro off → `done` pulses once at ≥6 cycles after `start`; popcount(`mine_map`)=5; bit 12 = 0.
- Same stimulus with the macro on → bits 6,7,8,11,12,13,16,17,18 are all 0; popcount = 5.
- Macro on, safe 0 (corner) → bits 0,1,5,6 are 0. Safe 24 → bits 18,19,23,24 are 0.
- Seed 0x0000 vs seed 0xACE1 → identical maps. Two runs with seed 0x1234 → identical maps.
- M=24, macro off, safe 12 → `mine_map` = all ones except bit 12; `done` pulses.
- Assert `rst` 3 cycles into PLACE → `mine_map`=0 and `busy`=0 immediately. A `start` pulse during PLACE is ignored and the map completes unchanged.
